// File: rtl/z2_bus_cycle_if.sv
// Zorro II slave bus-cycle signal bundle.
// Host strobes and sub-block requests in; phase and bus controls out.
interface z2_bus_cycle_if;
  logic       AS_n;
  logic       UDS_n;
  logic       LDS_n;
  logic       RW;
  logic       ACCESS;
  logic       DTACK_REQ;
  logic [1:0] z2_state;
  logic       DTACK_OE;
  logic       DBUF_OE_n;
  logic       DBUF_DIR;
  logic       wr_strobe;
  logic       timeout;

  modport master (
    output AS_n, UDS_n, LDS_n, RW,
    output ACCESS, DTACK_REQ,
    input  z2_state, DTACK_OE,
    input  DBUF_OE_n, DBUF_DIR,
    input  wr_strobe, timeout
  );

  modport slave (
    input  AS_n, UDS_n, LDS_n, RW,
    input  ACCESS, DTACK_REQ,
    output z2_state, DTACK_OE,
    output DBUF_OE_n, DBUF_DIR,
    output wr_strobe, timeout
  );
endinterface

// File: rtl/z2_bus_cycle.sv
// Zorro II slave bus-cycle sequencer: strobe sync, phase FSM,
// DTACK merge, data-buffer control and stalled-cycle timeout.
module z2_bus_cycle #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           CLK,
  input logic           RESET_n,
  z2_bus_cycle_if.slave bus
);

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'd0,
    Z2_START = 2'd1,
    Z2_DATA  = 2'd2,
    Z2_END   = 2'd3
  } z2_state_e;

  localparam logic [7:0] TO_LAST =
    8'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
  logic [SYNC_STAGES-1:0] uds_sync_q, uds_sync_d;
  logic [SYNC_STAGES-1:0] lds_sync_q, lds_sync_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;

  z2_state_e  state_q, state_d;
  logic       armed_q, armed_d;
  logic       access_q, access_d;
  logic       dir_q, dir_d;
  logic       dtack_oe_q, dtack_oe_d;
  logic       dbuf_oe_n_q, dbuf_oe_n_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       timeout_q, timeout_d;
  logic [7:0] cnt_q, cnt_d;

  logic as_s, uds_s, lds_s, ds_s, synced;

  assign as_s   = as_sync_q[SYNC_STAGES-1];
  assign uds_s  = uds_sync_q[SYNC_STAGES-1];
  assign lds_s  = lds_sync_q[SYNC_STAGES-1];
  assign ds_s   = !(uds_s && lds_s);
  // Preset chain values are not real samples; arm only on a true high.
  assign synced = flush_q[SYNC_STAGES-1];

  always_comb begin
    as_sync_d  = {as_sync_q[SYNC_STAGES-2:0], bus.AS_n};
    uds_sync_d = {uds_sync_q[SYNC_STAGES-2:0], bus.UDS_n};
    lds_sync_d = {lds_sync_q[SYNC_STAGES-2:0], bus.LDS_n};
    flush_d    = {flush_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    access_d    = access_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    wr_strobe_d = 1'b0;
    timeout_d   = 1'b0;
    if (as_s && synced) armed_d = 1'b1;
    unique case (state_q)
      Z2_IDLE: begin
        if (!as_s && bus.ACCESS && armed_q) begin
          state_d  = Z2_START;
          armed_d  = 1'b0;
          access_d = 1'b1;
          dir_d    = bus.RW;
        end
      end
      Z2_START: begin
        if (as_s) begin
          state_d = Z2_IDLE;
        end else if (dir_q || ds_s) begin
          state_d     = Z2_DATA;
          cnt_d       = 8'd0;
          wr_strobe_d = !dir_q;
        end
      end
      Z2_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (as_s) begin
          state_d = Z2_IDLE;
        end else if (bus.DTACK_REQ) begin
          state_d = Z2_END;
        end else if (cnt_q == TO_LAST) begin
          state_d   = Z2_END;
          timeout_d = 1'b1;
        end
      end
      Z2_END: begin
        if (as_s) state_d = Z2_IDLE;
      end
      default: state_d = Z2_IDLE;
    endcase
    if (state_d == Z2_IDLE) begin
      access_d = 1'b0;
      dir_d    = 1'b0;
    end
    dtack_oe_d  = (state_d == Z2_END);
    dbuf_oe_n_d = !(access_d && state_d != Z2_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_sync_q   <= '1;
      uds_sync_q  <= '1;
      lds_sync_q  <= '1;
      flush_q     <= '0;
      state_q     <= Z2_IDLE;
      armed_q     <= 1'b0;
      access_q    <= 1'b0;
      dir_q       <= 1'b0;
      cnt_q       <= 8'd0;
      dtack_oe_q  <= 1'b0;
      dbuf_oe_n_q <= 1'b1;
      wr_strobe_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      as_sync_q   <= as_sync_d;
      uds_sync_q  <= uds_sync_d;
      lds_sync_q  <= lds_sync_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      armed_q     <= armed_d;
      access_q    <= access_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      dtack_oe_q  <= dtack_oe_d;
      dbuf_oe_n_q <= dbuf_oe_n_d;
      wr_strobe_q <= wr_strobe_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.z2_state  = state_q;
  assign bus.DTACK_OE  = dtack_oe_q;
  assign bus.DBUF_OE_n = dbuf_oe_n_q;
  assign bus.DBUF_DIR  = dir_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_z2_bus_cycle.sv
// Directed bench for z2_bus_cycle with a per-cycle scoreboard.
// Vector order: {state[1:0], dtack_oe, dbuf_oe_n, dir, wr, timeout}.
module tb_z2_bus_cycle;

  logic CLK;
  logic RESET_n;
  int   cyc;
  int   checks;
  int   errors;

  z2_bus_cycle_if bus_if();

  z2_bus_cycle #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .bus(bus_if.slave)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [6:0] obs;

  localparam logic [6:0] IDLE_V = 7'b00_0_1_0_0_0;

  function automatic logic [6:0] pk(
    input logic [1:0] st, input logic dt,
    input logic oen, input logic dir,
    input logic wr, input logic to);
    return {st, dt, oen, dir, wr, to};
  endfunction

  task automatic push(input string tag,
                      input int c,
                      input logic [6:0] v);
    exp_t x;
    x.cyc = c;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      obs = {bus_if.z2_state, bus_if.DTACK_OE,
             bus_if.DBUF_OE_n, bus_if.DBUF_DIR,
             bus_if.wr_strobe, bus_if.timeout};
      checks++;
      assert (e.cyc == cyc && obs === e.v) else begin
        errors++;
        $error("FAIL %s@%0d: observed=%b expected=%b",
               e.tag, e.cyc, obs, e.v);
      end
    end
  end

  initial begin
    int c0;
    int c1;
    cyc    = 0;
    checks = 0;
    errors = 0;
    RESET_n          = 1'b0;
    bus_if.AS_n      = 1'b1;
    bus_if.UDS_n     = 1'b1;
    bus_if.LDS_n     = 1'b1;
    bus_if.RW        = 1'b1;
    bus_if.ACCESS    = 1'b0;
    bus_if.DTACK_REQ = 1'b0;

    push("reset", 1, IDLE_V);
    push("reset", 2, IDLE_V);
    tick(2);
    RESET_n = 1'b1;
    tick(5);

    // Read, DTACK_REQ held
    c0 = cyc;
    bus_if.AS_n      = 1'b0;
    bus_if.RW        = 1'b1;
    bus_if.ACCESS    = 1'b1;
    bus_if.DTACK_REQ = 1'b1;
    push("rd_sync", c0 + 1, IDLE_V);
    push("rd_sync", c0 + 2, IDLE_V);
    push("rd_start", c0 + 3, pk(2'd1, 0, 0, 1, 0, 0));
    push("rd_data", c0 + 4, pk(2'd2, 0, 0, 1, 0, 0));
    push("rd_end", c0 + 5, pk(2'd3, 1, 0, 1, 0, 0));
    wait_to(c0 + 6);
    bus_if.AS_n = 1'b1;
    push("rd_hold", c0 + 8, pk(2'd3, 1, 0, 1, 0, 0));
    push("rd_idle", c0 + 9, IDLE_V);
    wait_to(c0 + 10);
    bus_if.DTACK_REQ = 1'b0;
    tick(4);

    // Write, UDS late, ACCESS drops mid-cycle
    c0 = cyc;
    bus_if.AS_n   = 1'b0;
    bus_if.RW     = 1'b0;
    bus_if.ACCESS = 1'b1;
    for (int i = 3; i <= 6; i++)
      push("wr_start", c0 + i, pk(2'd1, 0, 0, 0, 0, 0));
    push("wr_strobe", c0 + 7, pk(2'd2, 0, 0, 0, 1, 0));
    push("wr_data", c0 + 8, pk(2'd2, 0, 0, 0, 0, 0));
    wait_to(c0 + 4);
    bus_if.UDS_n = 1'b0;
    wait_to(c0 + 5);
    bus_if.ACCESS = 1'b0;
    wait_to(c0 + 8);
    bus_if.DTACK_REQ = 1'b1;
    wait_to(c0 + 9);
    bus_if.DTACK_REQ = 1'b0;
    push("wr_end", c0 + 9, pk(2'd3, 1, 0, 0, 0, 0));
    push("wr_end2", c0 + 10, pk(2'd3, 1, 0, 0, 0, 0));
    wait_to(c0 + 10);
    bus_if.AS_n  = 1'b1;
    bus_if.UDS_n = 1'b1;
    push("wr_idle", c0 + 13, IDLE_V);
    wait_to(c0 + 13);
    tick(4);

    // Timeout after 8 cycles in DATA
    c0 = cyc;
    bus_if.AS_n   = 1'b0;
    bus_if.RW     = 1'b1;
    bus_if.ACCESS = 1'b1;
    push("to_start", c0 + 3, pk(2'd1, 0, 0, 1, 0, 0));
    for (int i = 4; i <= 11; i++)
      push("to_data", c0 + i, pk(2'd2, 0, 0, 1, 0, 0));
    push("to_pulse", c0 + 12, pk(2'd3, 1, 0, 1, 0, 1));
    push("to_end", c0 + 13, pk(2'd3, 1, 0, 1, 0, 0));
    wait_to(c0 + 14);
    bus_if.AS_n = 1'b1;
    push("to_hold", c0 + 16, pk(2'd3, 1, 0, 1, 0, 0));
    push("to_idle", c0 + 17, IDLE_V);
    wait_to(c0 + 17);
    tick(4);

    // Abort from DATA
    c0 = cyc;
    bus_if.AS_n = 1'b0;
    push("ab_start", c0 + 3, pk(2'd1, 0, 0, 1, 0, 0));
    for (int i = 4; i <= 7; i++)
      push("ab_data", c0 + i, pk(2'd2, 0, 0, 1, 0, 0));
    for (int i = 8; i <= 10; i++)
      push("ab_idle", c0 + i, IDLE_V);
    wait_to(c0 + 5);
    bus_if.AS_n = 1'b1;
    wait_to(c0 + 10);
    tick(4);

    // Miss: ACCESS low for the whole cycle
    c0 = cyc;
    bus_if.AS_n   = 1'b0;
    bus_if.ACCESS = 1'b0;
    for (int i = 1; i <= 8; i++)
      push("miss", c0 + i, IDLE_V);
    wait_to(c0 + 8);
    bus_if.AS_n = 1'b1;
    tick(4);
    bus_if.ACCESS = 1'b1;
    tick(1);

    // Reset in END with AS still low
    c0 = cyc;
    bus_if.AS_n      = 1'b0;
    bus_if.RW        = 1'b1;
    bus_if.DTACK_REQ = 1'b1;
    push("rst_pre", c0 + 5, pk(2'd3, 1, 0, 1, 0, 0));
    wait_to(c0 + 6);
    RESET_n = 1'b0;
    push("rst_async", c0 + 6, IDLE_V);
    wait_to(c0 + 7);
    RESET_n = 1'b1;
    for (int i = 7; i <= 14; i++)
      push("rst_norearm", c0 + i, IDLE_V);
    wait_to(c0 + 14);
    bus_if.AS_n = 1'b1;
    wait_to(c0 + 18);
    c1 = cyc;
    bus_if.AS_n = 1'b0;
    push("rst_new_idle", c1 + 2, IDLE_V);
    push("rst_new_start", c1 + 3, pk(2'd1, 0, 0, 1, 0, 0));
    push("rst_new_data", c1 + 4, pk(2'd2, 0, 0, 1, 0, 0));
    push("rst_new_end", c1 + 5, pk(2'd3, 1, 0, 1, 0, 0));
    wait_to(c1 + 6);
    bus_if.AS_n = 1'b1;
    push("rst_new_idle2", c1 + 9, IDLE_V);

    for (int i = 0; i < 50 && sb.size() > 0; i++)
      tick(1);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard: pending=%0d required=0",
               sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/z2_bus_cycle.md
Name: z2_bus_cycle

Overview:
- Zorro II slave bus-cycle sequencer for the card.
- Synchronises the host strobes (AS_n, UDS_n, LDS_n) into the CLK domain and tracks each cycle that hits one of the card's decoded regions.
- Publishes z2_state, which the autoconfig, RAM, IDE and control-register blocks use to gate their data phase.
- Merges their completion requests into one DTACK drive, controls the data-bus buffer, and times out stalled cycles.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the AS_n/UDS_n/LDS_n synchronisers; legal range 2-3.
- TIMEOUT_CYCLES, 64: CLK cycles allowed in Z2_DATA before a forced completion; legal range 4-255.

Ports:
- CLK  in  1  system clock.
- RESET_n  in  1  reset, asynchronous assert, active-low.
- AS_n  in  1  host address strobe, asynchronous.
- UDS_n  in  1  upper data strobe, asynchronous.
- LDS_n  in  1  lower data strobe, asynchronous.
- RW  in  1  host read(1)/write(0); stable while AS_n is low.
- ACCESS  in  1  combinational OR of the card's region decodes (ram, ide, ctrl, flash, autoconfig).
- DTACK_REQ  in  1  OR of the sub-block completion requests; a single-cycle pulse is sufficient.
- z2_state  out  2  bus phase: Z2_IDLE=0, Z2_START=1, Z2_DATA=2, Z2_END=3 (encoding fixed in globalparams.vh).
- DTACK_OE  out  1  1 = drive bus DTACK low.
- DBUF_OE_n  out  1  data buffer enable, active-low.
- DBUF_DIR  out  1  1 = card drives the host bus (read); 0 = host drives the card.
- wr_strobe  out  1  one-CLK pulse: write data is valid on the bus.
- timeout  out  1  one-CLK pulse: the cycle was force-completed.

Behaviour:
- Reset: asynchronous, RESET_n low. Required values:
  - z2_state=Z2_IDLE, DTACK_OE=0, DBUF_OE_n=1, DBUF_DIR=0, wr_strobe=0, timeout=0.
  - Synchroniser flops preset to 1; timeout counter cleared; access_q=0.
  - Reset asserted mid-cycle takes effect immediately. After release the block waits for as_s=1 before it accepts a new cycle.
- Synchronisers: as_s, uds_s, lds_s are the outputs of SYNC_STAGES-deep flop chains. ds_s = !(uds_s && lds_s), i.e. at least one data strobe asserted.
- Z2_IDLE:
  - Go to Z2_START when as_s=0 && ACCESS=1 && armed.
  - armed is set by observing as_s=1 and cleared on entry to Z2_START. This blocks re-triggering within the same AS assertion.
  - Latch access_q=1 and DBUF_DIR=RW on entry to Z2_START.
- Z2_START:
  - DBUF_OE_n=0.
  - Read (RW=1): go to Z2_DATA on the next edge.
  - Write: go to Z2_DATA on the first edge where ds_s=1.
  - If as_s=1 (aborted cycle), go to Z2_IDLE without asserting DTACK.
- Z2_DATA:
  - Write: wr_strobe=1 for the first cycle in this state only.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - DTACK_REQ=1: go to Z2_END.
  - Counter reaches TIMEOUT_CYCLES-1 with no DTACK_REQ: go to Z2_END and pulse timeout=1 for one cycle.
  - DTACK_REQ on the same edge as expiry: normal completion, timeout=0.
  - as_s=1: go to Z2_IDLE, no DTACK.
- Z2_END:
  - DTACK_OE=1 and DBUF_OE_n=0 while in this state.
  - On as_s=1 go to Z2_IDLE. DTACK_OE and DBUF_OE_n deassert in that same registered update, and access_q clears.
- DTACK_OE is asserted only in Z2_END.
- DBUF_OE_n=0 only in Z2_START, Z2_DATA and Z2_END.
- DTACK_REQ is ignored outside Z2_DATA.
- ACCESS changing after Z2_START entry has no effect.
- Back-to-back cycles: a new cycle needs as_s high for at least one CLK, then low again.
- Latency (SYNC_STAGES=2, read, DTACK_REQ held 1), counting from the first CLK edge sampling AS_n=0:
  - edge 2: as_s=0.
  - edge 3: Z2_START.
  - edge 4: Z2_DATA.
  - edge 5: Z2_END.
- All outputs are registered; no combinational path from the inputs to any output.

Test Plan:
- Read, SYNC_STAGES=2, ACCESS=1, DTACK_REQ=1:
  - Drop AS_n at edge 0 -> Z2_START at edge 3, Z2_DATA at edge 4, Z2_END and DTACK_OE=1 at edge 5.
  - DBUF_DIR=1, DBUF_OE_n=0 from edge 3.
  - Raise AS_n -> everything is idle 3 edges later.
- Write, RW=0, UDS_n falling 4 edges after AS_n:
  - Remain in Z2_START until ds_s=1.
  - wr_strobe is exactly one cycle at Z2_DATA entry; DBUF_DIR=0.
  - DTACK_REQ pulse 2 cycles later -> Z2_END.
- Timeout, DTACK_REQ=0, TIMEOUT_CYCLES=8:
  - Exactly 8 cycles in Z2_DATA, then Z2_END.
  - timeout=1 for one cycle; DTACK_OE=1 until AS_n rises.
- Abort: AS_n rises while in Z2_DATA -> Z2_IDLE, DTACK_OE never asserted, DBUF_OE_n=1.
- Miss: ACCESS=0 for a whole AS cycle -> state stays Z2_IDLE, all outputs at reset values.
- Reset mid-cycle: RESET_n low in Z2_END with AS_n still low, then released:
  - All outputs reset immediately.
  - No new cycle starts until AS_n goes high and then low again.
